// File: rtl/bigint_loader_if.sv
// Command, byte-stream and RAM-write bundle of the operand loader.
// master drives commands and bytes; slave is the loader itself.
interface bigint_loader_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned LEN_W  = 10
);
  logic              cmdStart;
  logic [LEN_W-1:0]  cmdLen;
  logic [7:0]        inData;
  logic              inValid;
  logic              inReady;
  logic [ADDR_W-1:0] wAddr;
  logic [63:0]       wData;
  logic              wEn;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cmdStart, cmdLen, inData, inValid,
    input  inReady, wAddr, wData, wEn, busy, done, err
  );

  modport slave (
    input  cmdStart, cmdLen, inData, inValid,
    output inReady, wAddr, wData, wEn, busy, done, err
  );
endinterface

// File: rtl/bigint_loader.sv
// Packs a big-endian byte stream into 64-bit little-endian limbs of the operand RAM,
// zero-filling every limb above the operand's top limb, then pulses done.
module bigint_loader #(
  parameter int unsigned WORDS  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned LEN_W  = 10
) (
  input logic            clk,
  input logic            reset,
  bigint_loader_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StClear, StLoad, StDone} state_t;

  localparam logic [LEN_W-1:0]  MaxLen   = LEN_W'(WORDS * 8);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(WORDS - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] word_idx_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [2:0]        lane_q;
  logic [55:0]       acc_q;

  logic [LEN_W-1:0]  len_m1;
  logic [ADDR_W-1:0] len_top;
  logic              len_ok;
  logic              xfer;

  assign len_m1  = bus.cmdLen - LEN_W'(1);
  assign len_top = ADDR_W'(len_m1 >> 3);
  assign len_ok  = (bus.cmdLen != '0) && (bus.cmdLen <= MaxLen);
  assign xfer    = bus.inValid && bus.inReady;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      word_idx_q  <= '0;
      clr_addr_q  <= '0;
      lane_q      <= '0;
      acc_q       <= '0;
      bus.inReady <= 1'b0;
      bus.wAddr   <= '0;
      bus.wData   <= '0;
      bus.wEn     <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      bus.wEn  <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cmdStart) begin
            if (len_ok) begin
              // word_idx holds the top limb index until LOAD starts counting down
              word_idx_q <= len_top;
              lane_q     <= len_m1[2:0];
              clr_addr_q <= LastAddr;
              acc_q      <= '0;
              bus.busy   <= 1'b1;
              if (len_top == LastAddr) begin
                state_q     <= StLoad;
                bus.inReady <= 1'b1;
              end else begin
                state_q <= StClear;
              end
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        StClear: begin
          bus.wEn    <= 1'b1;
          bus.wAddr  <= clr_addr_q;
          bus.wData  <= '0;
          clr_addr_q <= clr_addr_q - ADDR_W'(1);
          if (clr_addr_q == word_idx_q + ADDR_W'(1)) begin
            state_q     <= StLoad;
            bus.inReady <= 1'b1;
          end
        end
        StLoad: begin
          if (xfer) begin
            if (lane_q == 3'd0) begin
              bus.wEn    <= 1'b1;
              bus.wAddr  <= word_idx_q;
              bus.wData  <= {acc_q, bus.inData};
              acc_q      <= '0;
              lane_q     <= 3'd7;
              word_idx_q <= word_idx_q - ADDR_W'(1);
              if (word_idx_q == '0) begin
                state_q     <= StDone;
                bus.done    <= 1'b1;
                bus.inReady <= 1'b0;
              end
            end else begin
              acc_q  <= {acc_q[47:0], bus.inData};
              lane_q <= lane_q - 3'd1;
            end
          end
        end
        StDone: begin
          state_q  <= StIdle;
          bus.busy <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bigint_loader.sv
// Directed bench for bigint_loader: write log captured on the falling edge,
// expected RAM image built from the byte stream.
module tb_bigint_loader;
  localparam int unsigned WORDS  = 64;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned LEN_W  = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bigint_loader_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  bigint_loader #(.WORDS(WORDS), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [63:0]       wd_q[$];
  int                done_cnt, done_bad, err_cnt;
  bit                busy_seen, ready_seen;
  logic [7:0]        bytes[$];
  logic [63:0]       img[WORDS];

  always @(negedge clk) begin
    if (bus.wEn) begin
      wa_q.push_back(bus.wAddr);
      wd_q.push_back(bus.wData);
    end
    if (bus.done) begin
      done_cnt++;
      if (!bus.wEn || bus.wAddr != '0 || !bus.busy) done_bad++;
    end
    if (bus.err) err_cnt++;
    if (bus.busy) busy_seen = 1'b1;
    if (bus.inReady) ready_seen = 1'b1;
  end

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    done_bad = 0;
    err_cnt = 0;
    busy_seen = 1'b0;
    ready_seen = 1'b0;
  endtask

  function automatic void build_image();
    int n = bytes.size();
    for (int a = 0; a < WORDS; a++) img[a] = '0;
    for (int j = 0; j < n; j++) begin
      int p = n - 1 - j;
      img[p / 8][8 * (p % 8) +: 8] = bytes[j];
    end
  endfunction

  task automatic start_cmd(input int len);
    bus.cmdStart = 1'b1;
    bus.cmdLen = LEN_W'(len);
    @(negedge clk);
    bus.cmdStart = 1'b0;
  endtask

  // Called and returns on a falling edge; transfer happens on the rising edge between.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    if (gap) begin
      bus.inValid = 1'b0;
      bus.inData = 8'hEE;
      @(negedge clk);
    end
    bus.inData = b;
    bus.inValid = 1'b1;
    while (!bus.inReady && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!bus.inReady) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: inReady got 0 want 1 for byte %h", b);
    end
    @(negedge clk);
    bus.inValid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int t = 0;
    while (done_cnt == 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    ok = (done_cnt != 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_load(input int len, input bit gap, output bit ok);
    clear_mon();
    build_image();
    start_cmd(len);
    foreach (bytes[j]) send_byte(bytes[j], gap);
    wait_done(ok);
  endtask

  task automatic check_image(input string name, input bit ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL %s_done: timeout got done_cnt %0d want 1", name, done_cnt);
    end
    tests_run++;
    if (done_cnt != 1 || done_bad != 0) begin
      tests_failed++;
      $display("FAIL %s_done_pulse: got %0d pulses (%0d misaligned) want 1 (0)", name, done_cnt,
               done_bad);
    end
    tests_run++;
    if (wa_q.size() != WORDS) begin
      tests_failed++;
      $display("FAIL %s_wcount: got %0d writes want %0d", name, wa_q.size(), WORDS);
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        tests_run++;
        if (wa_q[i] !== ADDR_W'(WORDS - 1 - i) || wd_q[i] !== img[WORDS - 1 - i]) begin
          tests_failed++;
          $display("FAIL %s_write%0d: got addr %0d data %h want addr %0d data %h", name, i,
                   wa_q[i], wd_q[i], WORDS - 1 - i, img[WORDS - 1 - i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.inReady, bus.wEn, bus.busy, bus.done, bus.err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 00000",
               {bus.inReady, bus.wEn, bus.busy, bus.done, bus.err});
    end
    tests_run++;
    if (bus.wAddr !== '0 || bus.wData !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: got addr %0d data %h want 0 0", bus.wAddr, bus.wData);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_len8();
    bit ok;
    bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(8, 1'b0, ok);
    check_image("len8", ok);
    tests_run++;
    if (wd_q.size() != WORDS || wd_q[WORDS - 1] !== 64'h0102030405060708) begin
      tests_failed++;
      $display("FAIL len8_limb0: got %h want 0102030405060708",
               (wd_q.size() != 0) ? wd_q[wd_q.size() - 1] : 64'hx);
    end
  endtask

  task automatic test_partial();
    bit ok;
    bytes = '{8'hAA, 8'hBB, 8'hCC};
    run_load(3, 1'b0, ok);
    check_image("len3", ok);
    tests_run++;
    if (wd_q.size() != WORDS || wd_q[WORDS - 1] !== 64'h0000000000AABBCC) begin
      tests_failed++;
      $display("FAIL len3_limb0: got %h want 0000000000aabbcc",
               (wd_q.size() != 0) ? wd_q[wd_q.size() - 1] : 64'hx);
    end
  endtask

  task automatic test_gaps();
    bit ok;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    run_load(9, 1'b1, ok);
    check_image("len9", ok);
    tests_run++;
    if (wd_q.size() != WORDS || wd_q[WORDS - 2] !== 64'h11 ||
        wd_q[WORDS - 1] !== 64'h2233445566778899) begin
      tests_failed++;
      $display("FAIL len9_limbs: got %h %h want 0000000000000011 2233445566778899",
               (wd_q.size() > 1) ? wd_q[wd_q.size() - 2] : 64'hx,
               (wd_q.size() > 0) ? wd_q[wd_q.size() - 1] : 64'hx);
    end
  endtask

  task automatic test_full();
    bit ok;
    bytes.delete();
    for (int i = 0; i < WORDS * 8; i++) bytes.push_back(8'(i));
    run_load(WORDS * 8, 1'b0, ok);
    check_image("len512", ok);
    tests_run++;
    if (wd_q.size() != WORDS || wa_q[0] !== ADDR_W'(WORDS - 1) ||
        wd_q[0] !== 64'h0001020304050607 || wd_q[WORDS - 1] !== 64'hF8F9FAFBFCFDFEFF) begin
      tests_failed++;
      $display("FAIL len512_ends: got first %h last %h want 0001020304050607 f8f9fafbfcfdfeff",
               (wd_q.size() > 0) ? wd_q[0] : 64'hx,
               (wd_q.size() > 0) ? wd_q[wd_q.size() - 1] : 64'hx);
    end
  endtask

  task automatic test_bad_len();
    bit ok;
    int lens[2] = '{0, WORDS * 8 + 1};
    foreach (lens[k]) begin
      clear_mon();
      start_cmd(lens[k]);
      repeat (4) @(negedge clk);
      tests_run++;
      if (err_cnt != 1) begin
        tests_failed++;
        $display("FAIL badlen%0d_err: got %0d err cycles want 1", lens[k], err_cnt);
      end
      tests_run++;
      if (wa_q.size() != 0 || busy_seen || ready_seen) begin
        tests_failed++;
        $display("FAIL badlen%0d_quiet: got writes %0d busy %0b ready %0b want 0 0 0", lens[k],
                 wa_q.size(), busy_seen, ready_seen);
      end
    end
    bytes = '{8'hAB, 8'hCD};
    run_load(2, 1'b0, ok);
    check_image("after_err", ok);
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    clear_mon();
    start_cmd(16);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 1'b0);
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.inReady, bus.wEn, bus.busy, bus.done, bus.err} !== 5'b0 ||
        bus.wAddr !== '0 || bus.wData !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got flags %b addr %0d data %h want 00000 0 0",
               {bus.inReady, bus.wEn, bus.busy, bus.done, bus.err}, bus.wAddr, bus.wData);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    repeat (5) @(negedge clk);
    tests_run++;
    if (done_cnt != 0 || busy_seen || wa_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_abandon: got done %0d busy %0b writes %0d want 0 0 0", done_cnt,
               busy_seen, wa_q.size());
    end
    // Fresh load with an invalid cmdStart injected while busy: must be ignored, no err.
    bytes = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8};
    clear_mon();
    build_image();
    start_cmd(8);
    repeat (3) @(negedge clk);
    start_cmd(0);
    foreach (bytes[j]) send_byte(bytes[j], 1'b0);
    wait_done(ok);
    check_image("post_reset", ok);
    tests_run++;
    if (err_cnt != 0) begin
      tests_failed++;
      $display("FAIL busy_cmd_ignored: got %0d err cycles want 0", err_cnt);
    end
  endtask

  initial begin
    bus.cmdStart = 1'b0;
    bus.cmdLen = '0;
    bus.inData = '0;
    bus.inValid = 1'b0;
    clear_mon();
    test_reset();
    test_len8();
    test_partial();
    test_gaps();
    test_full();
    test_bad_len();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
